// File: rtl/upd7800_pkg.sv
// =====================================================================
// upd7800_pkg : shared types, opcodes and reset values for the uPD7800 subset core
// Rev 1.0
// =====================================================================
`default_nettype none

package upd7800_pkg;

  typedef enum logic [2:0] {
    ST_RST   = 3'd0,
    ST_FETCH = 3'd1,
    ST_RD1   = 3'd2,
    ST_RD2   = 3'd3,
    ST_WR    = 3'd4
  } state_e;

  typedef enum logic [1:0] {
    T1 = 2'd0,
    T2 = 2'd1,
    T3 = 2'd2
  } tstate_e;

  // Which clock enable the phase tracker will accept next
  typedef enum logic [1:0] {
    PH_CP1P = 2'd0,
    PH_CP1N = 2'd1,
    PH_CP2P = 2'd2,
    PH_CP2N = 2'd3
  } phase_e;

  typedef enum logic [1:0] {
    K_NOP  = 2'd0,
    K_JMP  = 2'd1,
    K_MVIA = 2'd2,
    K_STAW = 2'd3
  } kind_e;

  localparam logic [7:0]  OP_NOP  = 8'h00;
  localparam logic [7:0]  OP_JMP  = 8'h54;
  localparam logic [7:0]  OP_MVIA = 8'h69;
  localparam logic [7:0]  OP_STAW = 8'h63;

  localparam logic [15:0] RST_A   = 16'h0000;
  localparam logic [15:0] RST_PC  = 16'h0000;
  localparam logic [7:0]  RST_DBO = 8'h00;
  localparam logic [7:0]  RST_ACC = 8'h00;
  localparam logic [7:0]  V_REG   = 8'h00;

  // Unknown or unlisted opcodes fall through to NOP, so X never reaches the sequencer
  function automatic kind_e decode_op(input logic [7:0] op);
    case (op)
      OP_JMP:  return K_JMP;
      OP_MVIA: return K_MVIA;
      OP_STAW: return K_STAW;
      default: return K_NOP;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/upd7800_if.sv
// =====================================================================
// upd7800_if : external memory bus (address, data in/out, output enable, M1)
// Rev 1.0
// =====================================================================
`default_nettype none

interface upd7800_if;
  logic [15:0] A;
  logic [7:0]  DB_I;
  logic [7:0]  DB_O;
  logic        DB_OE;
  logic        M1;

  modport master (output A, output DB_O, output DB_OE, output M1, input DB_I);
  modport slave  (input A, input DB_O, input DB_OE, input M1, output DB_I);
endinterface

`default_nettype wire

// File: rtl/upd7800_phase.sv
// =====================================================================
// upd7800_phase : CP enable rotation tracker, cp2 level and T1-T3 strobes
// Rev 1.0
// =====================================================================
`default_nettype none

module upd7800_phase
  import upd7800_pkg::*;
(
  input  logic clk_i,
  input  logic rst_i,
  input  logic cp1p_i,
  input  logic cp1n_i,
  input  logic cp2p_i,
  input  logic cp2n_i,
  output logic t1_start_o,
  output logic t2_start_o,
  output logic t3_sample_o
);

  phase_e  ph_q, ph_d;
  tstate_e t_q, t_d;
  logic    run_q, run_d;
  logic    cp2_q, cp2_d;
  logic    w_cp1p, w_cp1n, w_cp2p, w_cp2n;

  // An enable counts only when it is the next one in the rotation
  assign w_cp1p = cp1p_i && (ph_q == PH_CP1P);
  assign w_cp1n = cp1n_i && (ph_q == PH_CP1N);
  assign w_cp2p = cp2p_i && (ph_q == PH_CP2P);
  assign w_cp2n = cp2n_i && (ph_q == PH_CP2N);

  always_comb begin
    ph_d  = ph_q;
    t_d   = t_q;
    run_d = run_q;
    cp2_d = cp2_q;
    if (w_cp1p) begin
      ph_d  = PH_CP1N;
      run_d = 1'b1;
      if (run_q) begin
        case (t_q)
          T1:      t_d = T2;
          T2:      t_d = T3;
          default: t_d = T1;
        endcase
      end else begin
        t_d = T1;
      end
    end
    if (w_cp1n) ph_d = PH_CP2P;
    if (w_cp2p) begin
      ph_d  = PH_CP2N;
      cp2_d = 1'b1;
    end
    if (w_cp2n) begin
      ph_d  = PH_CP1P;
      cp2_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ph_q  <= PH_CP1P;
      t_q   <= T1;
      run_q <= 1'b0;
      cp2_q <= 1'b0;
    end else begin
      ph_q  <= ph_d;
      t_q   <= t_d;
      run_q <= run_d;
      cp2_q <= cp2_d;
    end
  end

  // The very first accepted CP1 rising edge opens T1 without advancing
  assign t1_start_o  = w_cp1p && (!run_q || (t_q == T3));
  assign t2_start_o  = w_cp1p && run_q && (t_q == T1);
  assign t3_sample_o = w_cp2n && run_q && (t_q == T3);

endmodule

`default_nettype wire

// File: rtl/upd7800_cpu.sv
// =====================================================================
// upd7800_cpu : uPD7800-subset core - bus-cycle FSM, PC/ACC/W registers, bus drive
// Rev 1.0
// =====================================================================
`default_nettype none

module upd7800_cpu
  import upd7800_pkg::*;
(
  input  logic      CLK,
  input  logic      RESET,
  input  logic      CP1_POSEDGE,
  input  logic      CP1_NEGEDGE,
  input  logic      CP2_POSEDGE,
  input  logic      CP2_NEGEDGE,
  upd7800_if.master bus
);

  state_e      state_q, state_d;
  kind_e       kind_q, kind_d;
  logic [15:0] pc_q, pc_d;
  logic [7:0]  acc_q, acc_d;
  logic [15:0] w_q, w_d;
  logic [15:0] a_q, a_d;
  logic [7:0]  dbo_q, dbo_d;
  logic        dboe_q, dboe_d;
  logic        m1_q, m1_d;
  logic [15:0] w_tgt;
  logic        w_t1_start, w_t2_start, w_t3_sample;

  upd7800_phase u_phase (
    .clk_i       (CLK),
    .rst_i       (RESET),
    .cp1p_i      (CP1_POSEDGE),
    .cp1n_i      (CP1_NEGEDGE),
    .cp2p_i      (CP2_POSEDGE),
    .cp2n_i      (CP2_NEGEDGE),
    .t1_start_o  (w_t1_start),
    .t2_start_o  (w_t2_start),
    .t3_sample_o (w_t3_sample)
  );

  always_comb begin
    state_d = state_q;
    kind_d  = kind_q;
    pc_d    = pc_q;
    acc_d   = acc_q;
    w_d     = w_q;
    a_d     = a_q;
    dbo_d   = dbo_q;
    dboe_d  = dboe_q;
    m1_d    = m1_q;
    w_tgt   = pc_q;

    if (w_t3_sample) begin
      case (state_q)
        ST_FETCH: kind_d     = decode_op(bus.DB_I);
        ST_RD1:   w_d[7:0]   = bus.DB_I;
        ST_RD2:   w_d[15:8]  = bus.DB_I;
        default:  ;
      endcase
    end

    if (w_t2_start && (state_q == ST_WR)) begin
      dbo_d  = acc_q;
      dboe_d = 1'b1;
    end

    // End of T3: retire the finished cycle and launch the next one
    if (w_t1_start) begin
      dboe_d = 1'b0;
      case (state_q)
        ST_RST:   state_d = ST_FETCH;
        ST_FETCH: state_d = (kind_q == K_NOP) ? ST_FETCH : ST_RD1;
        ST_RD1: begin
          case (kind_q)
            K_JMP:   state_d = ST_RD2;
            K_STAW:  state_d = ST_WR;
            K_MVIA: begin
              acc_d   = w_q[7:0];
              state_d = ST_FETCH;
            end
            default: state_d = ST_FETCH;
          endcase
        end
        ST_RD2: begin
          w_tgt   = w_q;
          state_d = ST_FETCH;
        end
        default:  state_d = ST_FETCH;
      endcase

      if (state_d == ST_WR) begin
        a_d = {V_REG, w_q[7:0]};
      end else begin
        a_d  = w_tgt;
        pc_d = w_tgt + 16'd1;
      end
      m1_d = (state_d == ST_FETCH);
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q <= ST_RST;
      kind_q  <= K_NOP;
      pc_q    <= RST_PC;
      acc_q   <= RST_ACC;
      w_q     <= 16'h0000;
      a_q     <= RST_A;
      dbo_q   <= RST_DBO;
      dboe_q  <= 1'b0;
      m1_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      kind_q  <= kind_d;
      pc_q    <= pc_d;
      acc_q   <= acc_d;
      w_q     <= w_d;
      a_q     <= a_d;
      dbo_q   <= dbo_d;
      dboe_q  <= dboe_d;
      m1_q    <= m1_d;
    end
  end

  assign bus.A     = a_q;
  assign bus.DB_O  = dbo_q;
  assign bus.DB_OE = dboe_q;
  assign bus.M1    = m1_q;

endmodule

`default_nettype wire

// File: tb/tb_upd7800_cpu.sv
// =====================================================================
// tb_upd7800_cpu : scoreboard bench for the uPD7800-subset core
// Rev 1.0
// =====================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_upd7800_cpu;

  typedef struct packed {
    logic [15:0] a;
    logic        m1;
    logic        wr;
    logic [7:0]  d;
  } cyc_t;

  logic CLK = 1'b0;
  logic RESET = 1'b1;
  logic CP1_POSEDGE = 1'b0, CP1_NEGEDGE = 1'b0, CP2_POSEDGE = 1'b0, CP2_NEGEDGE = 1'b0;
  logic real_cp1p = 1'b0;
  logic glitch = 1'b0;
  logic mem_en = 1'b0;
  logic [7:0] mem [0:255];
  int   rot = 0;
  int   clk_cnt = 0;
  int   n_cmp = 0;
  int   n_err = 0;
  cyc_t sb[$];

  upd7800_if bus();

  upd7800_cpu dut (
    .CLK         (CLK),
    .RESET       (RESET),
    .CP1_POSEDGE (CP1_POSEDGE),
    .CP1_NEGEDGE (CP1_NEGEDGE),
    .CP2_POSEDGE (CP2_POSEDGE),
    .CP2_NEGEDGE (CP2_NEGEDGE),
    .bus         (bus)
  );

  assign bus.DB_I = mem_en ? mem[bus.A[7:0]] : 8'hzz;

  always #125 CLK = ~CLK;   // 4 MHz
  always @(posedge CLK) clk_cnt <= clk_cnt + 1;

  initial begin
    forever begin
      @(negedge CLK);
      CP1_POSEDGE = (rot == 0) || (glitch && (rot == 1 || rot == 2));
      CP1_NEGEDGE = (rot == 1);
      CP2_POSEDGE = (rot == 2);
      CP2_NEGEDGE = (rot == 3);
      real_cp1p   = (rot == 0);
      rot = (rot + 1) % 4;
    end
  end

  function automatic cyc_t mk(input logic [15:0] a, input logic m1, input logic wr, input logic [7:0] d);
    cyc_t c;
    c.a = a; c.m1 = m1; c.wr = wr; c.d = d;
    return c;
  endfunction

  task automatic step_state();
    int n = 0;
    do begin
      @(posedge CLK);
      n++;
    end while (!real_cp1p && n < 8);
    #1;
    if (!real_cp1p) begin
      n_cmp++; n_err++;
      $display("FAIL step_timeout: no CP1 rising edge within %0d clocks", n);
    end
  endtask

  task automatic load_mem(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2, input logic [7:0] b3);
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    mem[0] = b0; mem[1] = b1; mem[2] = b2; mem[3] = b3;
  endtask

  task automatic do_reset();
    @(negedge CLK);
    RESET = 1'b1;
    repeat (6) @(negedge CLK);
    RESET = 1'b0;
  endtask

  task automatic test_reset();
    mem_en = 1'b0;
    for (int i = 0; i < 44; i++) begin
      @(negedge CLK);
      n_cmp++;
      if ($isunknown({bus.A, bus.M1, bus.DB_OE, bus.DB_O}) || bus.A !== 16'h0000 ||
          bus.M1 !== 1'b0 || bus.DB_OE !== 1'b0 || bus.DB_O !== 8'h00 || dut.u_phase.cp2_q !== 1'b0) begin
        n_err++;
        $display("FAIL reset_hold[%0d]: A=%h M1=%b OE=%b DBO=%h cp2=%b, required 0000/0/0/00/0",
                 i, bus.A, bus.M1, bus.DB_OE, bus.DB_O, dut.u_phase.cp2_q);
      end
    end
  endtask

  task automatic test_z_nop();
    cyc_t e;
    int   t_prev;
    mem_en = 1'b0;
    do_reset();
    for (int i = 0; i < 4; i++) sb.push_back(mk(16'(i), 1'b1, 1'b0, 8'h00));
    t_prev = -1;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      step_state();
      n_cmp++;
      if (bus.A !== e.a || bus.M1 !== e.m1 || bus.DB_OE !== 1'b0) begin
        n_err++;
        $display("FAIL znop_t1: A=%h M1=%b OE=%b, required A=%h M1=%b OE=0", bus.A, bus.M1, bus.DB_OE, e.a, e.m1);
      end
      if (t_prev >= 0) begin
        n_cmp++;
        if (clk_cnt - t_prev !== 12) begin
          n_err++;
          $display("FAIL znop_len: cycle took %0d clocks, required 12", clk_cnt - t_prev);
        end
      end
      t_prev = clk_cnt;
      step_state(); step_state();
    end
  endtask

  task automatic test_jmp();
    cyc_t e;
    load_mem(8'h54, 8'h34, 8'h12, 8'h00);
    mem_en = 1'b1;
    do_reset();
    sb.push_back(mk(16'h0000, 1'b1, 1'b0, 8'h00));
    sb.push_back(mk(16'h0001, 1'b0, 1'b0, 8'h00));
    sb.push_back(mk(16'h0002, 1'b0, 1'b0, 8'h00));
    sb.push_back(mk(16'h1234, 1'b1, 1'b0, 8'h00));
    sb.push_back(mk(16'h1235, 1'b1, 1'b0, 8'h00));
    while (sb.size() > 0) begin
      e = sb.pop_front();
      step_state();
      n_cmp++;
      if (bus.A !== e.a || bus.M1 !== e.m1) begin
        n_err++;
        $display("FAIL jmp_t1: A=%h M1=%b, required A=%h M1=%b", bus.A, bus.M1, e.a, e.m1);
      end
      step_state(); step_state();
      n_cmp++;
      if (bus.M1 !== e.m1 || bus.DB_OE !== 1'b0) begin
        n_err++;
        $display("FAIL jmp_t3: M1=%b OE=%b, required M1=%b OE=0 at A=%h", bus.M1, bus.DB_OE, e.m1, e.a);
      end
    end
  endtask

  task automatic test_mvi_staw();
    cyc_t e;
    load_mem(8'h69, 8'h5A, 8'h63, 8'h10);
    mem_en = 1'b1;
    do_reset();
    sb.push_back(mk(16'h0000, 1'b1, 1'b0, 8'h00));
    sb.push_back(mk(16'h0001, 1'b0, 1'b0, 8'h00));
    sb.push_back(mk(16'h0002, 1'b1, 1'b0, 8'h00));
    sb.push_back(mk(16'h0003, 1'b0, 1'b0, 8'h00));
    sb.push_back(mk(16'h0010, 1'b0, 1'b1, 8'h5A));
    sb.push_back(mk(16'h0004, 1'b1, 1'b0, 8'h00));
    while (sb.size() > 0) begin
      e = sb.pop_front();
      step_state();
      n_cmp++;
      if (bus.A !== e.a || bus.M1 !== e.m1 || bus.DB_OE !== 1'b0) begin
        n_err++;
        $display("FAIL staw_t1: A=%h M1=%b OE=%b, required A=%h M1=%b OE=0", bus.A, bus.M1, bus.DB_OE, e.a, e.m1);
      end
      step_state();
      n_cmp++;
      if (bus.DB_OE !== e.wr || (e.wr && bus.DB_O !== e.d)) begin
        n_err++;
        $display("FAIL staw_t2: OE=%b DBO=%h, required OE=%b DBO=%h at A=%h", bus.DB_OE, bus.DB_O, e.wr, e.d, e.a);
      end
      step_state();
      n_cmp++;
      if (bus.DB_OE !== e.wr || bus.M1 !== e.m1 || (e.wr && bus.DB_O !== e.d)) begin
        n_err++;
        $display("FAIL staw_t3: OE=%b M1=%b DBO=%h, required OE=%b M1=%b DBO=%h", bus.DB_OE, bus.M1, bus.DB_O, e.wr, e.m1, e.d);
      end
    end
  endtask

  task automatic test_reset_mid_write();
    cyc_t e;
    load_mem(8'h69, 8'h5A, 8'h63, 8'h10);
    mem_en = 1'b1;
    do_reset();
    sb.push_back(mk(16'h0000, 1'b1, 1'b0, 8'h00));
    sb.push_back(mk(16'h0001, 1'b0, 1'b0, 8'h00));
    sb.push_back(mk(16'h0002, 1'b1, 1'b0, 8'h00));
    sb.push_back(mk(16'h0003, 1'b0, 1'b0, 8'h00));
    sb.push_back(mk(16'h0010, 1'b0, 1'b1, 8'h5A));
    while (sb.size() > 0) begin
      e = sb.pop_front();
      step_state();
      step_state();
      if (e.wr) begin
        n_cmp++;
        if (bus.DB_OE !== 1'b1 || bus.A !== e.a) begin
          n_err++;
          $display("FAIL abort_pre: OE=%b A=%h, required OE=1 A=%h", bus.DB_OE, bus.A, e.a);
        end
        #20 RESET = 1'b1;
        #1;
        n_cmp++;
        if (bus.DB_OE !== 1'b0 || bus.A !== 16'h0000 || bus.M1 !== 1'b0) begin
          n_err++;
          $display("FAIL abort_now: OE=%b A=%h M1=%b, required OE=0 A=0000 M1=0", bus.DB_OE, bus.A, bus.M1);
        end
      end else begin
        step_state();
      end
    end
    repeat (5) @(negedge CLK);
    RESET = 1'b0;
    step_state();
    n_cmp++;
    if (bus.A !== 16'h0000 || bus.M1 !== 1'b1 || bus.DB_OE !== 1'b0) begin
      n_err++;
      $display("FAIL abort_restart: A=%h M1=%b OE=%b, required A=0000 M1=1 OE=0", bus.A, bus.M1, bus.DB_OE);
    end
  endtask

  task automatic test_pc_wrap();
    cyc_t e;
    load_mem(8'h54, 8'hFF, 8'hFF, 8'h00);
    mem_en = 1'b1;
    do_reset();
    sb.push_back(mk(16'h0000, 1'b1, 1'b0, 8'h00));
    sb.push_back(mk(16'h0001, 1'b0, 1'b0, 8'h00));
    sb.push_back(mk(16'h0002, 1'b0, 1'b0, 8'h00));
    sb.push_back(mk(16'hFFFF, 1'b1, 1'b0, 8'h00));
    sb.push_back(mk(16'h0000, 1'b1, 1'b0, 8'h00));
    while (sb.size() > 0) begin
      e = sb.pop_front();
      step_state();
      n_cmp++;
      if (bus.A !== e.a || bus.M1 !== e.m1) begin
        n_err++;
        $display("FAIL wrap_t1: A=%h M1=%b, required A=%h M1=%b", bus.A, bus.M1, e.a, e.m1);
      end
      step_state(); step_state();
    end
  endtask

  task automatic test_cp2();
    logic e;
    mem_en = 1'b0;
    do_reset();
    step_state();
    for (int i = 0; i < 8; i++) begin
      @(posedge CLK);
      e = CP2_POSEDGE;
      #1;
      n_cmp++;
      if (dut.u_phase.cp2_q !== e) begin
        n_err++;
        $display("FAIL cp2_level[%0d]: cp2=%b, required %b", i, dut.u_phase.cp2_q, e);
      end
    end
  endtask

  task automatic test_out_of_rotation();
    cyc_t e;
    int   t_prev;
    mem_en = 1'b0;
    do_reset();
    glitch = 1'b1;
    for (int i = 0; i < 3; i++) sb.push_back(mk(16'(i), 1'b1, 1'b0, 8'h00));
    t_prev = -1;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      step_state();
      n_cmp++;
      if (bus.A !== e.a || bus.M1 !== e.m1) begin
        n_err++;
        $display("FAIL glitch_t1: A=%h M1=%b, required A=%h M1=%b", bus.A, bus.M1, e.a, e.m1);
      end
      if (t_prev >= 0) begin
        n_cmp++;
        if (clk_cnt - t_prev !== 12) begin
          n_err++;
          $display("FAIL glitch_len: cycle took %0d clocks, required 12", clk_cnt - t_prev);
        end
      end
      t_prev = clk_cnt;
      step_state(); step_state();
    end
    glitch = 1'b0;
  endtask

  initial begin
    test_reset();
    test_z_nop();
    test_jmp();
    test_mvi_staw();
    test_reset_mid_write();
    test_pc_wrap();
    test_cp2();
    test_out_of_rotation();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

`default_nettype wire
